// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture scheduler.
//   SAMPLE_W    : width of one ADC sample
//   OVF_CNT_W   : width of the optional per-channel dropped-sample counters
//   cap_state_e : capture FSM state encoding
package adc_capture_pkg;

    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned OVF_CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDone
    } cap_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants at most one requester per cycle, searching from the
// requester after the last granted one.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_i       : request vector
//   gnt_o       : one-hot grant
//   gnt_valid_o : some request was granted this cycle
//   gnt_idx_o   : index of the granted requester
module rr_arbiter #(
    parameter int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        // Candidate order ptr+1 .. ptr+N, so the last winner comes last.
        for (int i = 1; i <= int'(N); i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % int'(N));
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
        ptr_d = gnt_valid_o ? gnt_idx_o : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adc_capture_scheduler.sv
// Multi-channel ADC capture scheduler: buffers one sample per channel and writes the
// channels into per-channel regions of a single BRAM write port, round-robin.
//   clk, rst_n        : clock, asynchronous active-low reset
//   data, data_valid  : per-channel samples and one-cycle qualifiers
//   start, abort      : capture control pulses (abort wins)
//   num_samples       : samples per channel, 0 or > DEPTH_PER_CH means DEPTH_PER_CH
//   cnv_enable, busy  : high while capturing
//   done              : capture complete
//   overflow          : sticky per-channel dropped-sample flags
//   bram_we/addr/wdata: registered BRAM write port, addr = {channel, offset}
// Optional feature: define ADC_CAPTURE_OVF_COUNT_EN to add ovf_count, saturating
// per-channel dropped-sample counters.
module adc_capture_scheduler
    import adc_capture_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DEPTH_PER_CH = 1024,
    localparam int unsigned CH_W   = $clog2(NUM_CHANNELS),
    localparam int unsigned OFS_W  = $clog2(DEPTH_PER_CH),
    localparam int unsigned ADDR_W = CH_W + OFS_W
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_CHANNELS-1:0][SAMPLE_W-1:0]  data,
    input  logic [NUM_CHANNELS-1:0]                data_valid,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [OFS_W:0]                         num_samples,
    output logic                                   cnv_enable,
    output logic                                   busy,
    output logic                                   done,
    output logic [NUM_CHANNELS-1:0]                overflow,
    output logic                                   bram_we,
    output logic [ADDR_W-1:0]                      bram_addr,
    output logic [SAMPLE_W-1:0]                    bram_wdata
`ifdef ADC_CAPTURE_OVF_COUNT_EN
    ,
    output logic [NUM_CHANNELS-1:0][OVF_CNT_W-1:0] ovf_count
`endif
);

    localparam logic [OFS_W:0] DepthVal = (OFS_W + 1)'(DEPTH_PER_CH);

    cap_state_e                           state_q, state_d;
    logic [OFS_W:0]                       target_q, target_d;
    logic [NUM_CHANNELS-1:0][OFS_W:0]     cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0]              pend_v_q, pend_v_d;
    logic [NUM_CHANNELS-1:0][SAMPLE_W-1:0] pend_data_q, pend_data_d;
    logic [NUM_CHANNELS-1:0]              overflow_q, overflow_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic                                 we_q, we_d;
    logic [ADDR_W-1:0]                    addr_q, addr_d;
    logic [SAMPLE_W-1:0]                  wdata_q, wdata_d;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
    logic [NUM_CHANNELS-1:0][OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
`endif

    logic [NUM_CHANNELS-1:0] arb_req;
    logic [NUM_CHANNELS-1:0] gnt;
    logic                    gnt_valid;
    logic [CH_W-1:0]         gnt_idx;
    logic                    capturing;

    assign capturing = (state_q == StCapture);
    // No grant in the abort cycle, so nothing is written once abort is seen.
    assign arb_req   = pend_v_q & {NUM_CHANNELS{capturing && !abort}};

    rr_arbiter #(
        .N (NUM_CHANNELS)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (arb_req),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        logic all_done;
        state_d     = state_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        overflow_d  = overflow_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
        ovf_cnt_d   = ovf_cnt_q;
`endif

        all_done = (pend_v_q == '0);
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
            if (cnt_q[c] != target_q) begin
                all_done = 1'b0;
            end
        end

        if (abort) begin
            state_d  = StIdle;
            pend_v_d = '0;
        end else if (start && !capturing) begin
            state_d    = StCapture;
            cnt_d      = '0;
            pend_v_d   = '0;
            overflow_d = '0;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
            ovf_cnt_d  = '0;
`endif
            if (num_samples == '0 || num_samples > DepthVal) begin
                target_d = DepthVal;
            end else begin
                target_d = num_samples;
            end
        end else if (capturing) begin
            if (gnt_valid) begin
                we_d              = 1'b1;
                addr_d            = {gnt_idx, cnt_q[gnt_idx][OFS_W-1:0]};
                wdata_d           = pend_data_q[gnt_idx];
                cnt_d[gnt_idx]    = cnt_q[gnt_idx] + 1'b1;
                pend_v_d[gnt_idx] = 1'b0;
            end
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                // Count the in-flight sample so a channel never exceeds its target.
                if (data_valid[c] &&
                    (cnt_q[c] + {{OFS_W{1'b0}}, pend_v_q[c]}) < target_q) begin
                    if (!pend_v_q[c] || gnt[c]) begin
                        pend_v_d[c]    = 1'b1;
                        pend_data_d[c] = data[c];
                    end else begin
                        overflow_d[c] = 1'b1;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
                        if (ovf_cnt_q[c] != '1) begin
                            ovf_cnt_d[c] = ovf_cnt_q[c] + 1'b1;
                        end
`endif
                    end
                end
            end
            if (all_done) begin
                state_d = StDone;
            end
        end

        busy_d = (state_d == StCapture);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            target_q    <= '0;
            cnt_q       <= '0;
            pend_v_q    <= '0;
            pend_data_q <= '0;
            overflow_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
            ovf_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
            ovf_cnt_q   <= ovf_cnt_d;
`endif
        end
    end

    assign cnv_enable = busy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
    assign ovf_count  = ovf_cnt_q;
`endif

endmodule

// File: doc/adc_capture_scheduler.md
ADC_CAPTURE_SCHEDULER -- requirements
Module: adc_capture_scheduler

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, number of ADC channels sharing one BRAM write port.
REQ-002 Parameter DEPTH_PER_CH, default 1024, samples per channel region; power of two.
REQ-003 Derived constants: CH_W = clog2(NUM_CHANNELS), OFS_W = clog2(DEPTH_PER_CH), ADDR_W = CH_W + OFS_W.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data  input  [NUM_CHANNELS][16]  per-channel ADC sample.
REQ-007 data_valid  input  NUM_CHANNELS  one-cycle strobe per channel qualifying data.
REQ-008 start  input  1  pulse; begins a capture.
REQ-009 abort  input  1  pulse; terminates a capture.
REQ-010 num_samples  input  OFS_W+1  samples per channel; sampled on accepted start.
REQ-011 cnv_enable  output  1  high only in CAPTURE; gates ADC conversions.
REQ-012 busy  output  1  high in CAPTURE.
REQ-013 done  output  1  high in DONE.
REQ-014 overflow  output  NUM_CHANNELS  sticky per-channel dropped-sample flag.
REQ-015 bram_we  output  1  registered write strobe.
REQ-016 bram_addr  output  ADDR_W  {channel index, sample offset}.
REQ-017 bram_wdata  output  16  sample being written.

Function
REQ-018 FSM states IDLE, CAPTURE, DONE; IDLE->CAPTURE and DONE->CAPTURE on start; CAPTURE->DONE when every channel count equals target and no pending sample; any state->IDLE on abort.
REQ-019 start in CAPTURE shall be ignored; abort and start in the same cycle: abort wins.
REQ-020 On accepted start: per-channel counts, pending flags and overflow shall clear; target = num_samples, with 0 meaning DEPTH_PER_CH; values above DEPTH_PER_CH saturate to DEPTH_PER_CH.
REQ-021 In CAPTURE, data_valid on channel c with count+pending below target shall load a one-entry pending register for c.
REQ-022 data_valid on c while c pending and not granted that cycle shall set overflow[c] and drop the new sample; old sample kept.
REQ-023 data_valid and grant on the same channel in the same cycle shall reload pending without overflow.
REQ-024 data_valid after a channel reaches target, or outside CAPTURE, shall be ignored with no overflow.
REQ-025 Round-robin arbiter shall grant at most one pending channel per cycle, searching from the channel after the last grant; no channel waits more than NUM_CHANNELS cycles.
REQ-026 Grant shall register bram_we=1, bram_addr={c, count[c]}, bram_wdata=pending[c], then increment count[c]; latency data_valid to bram_we is 2 cycles.
REQ-027 bram_we shall be a one-cycle pulse per write; bram_addr/bram_wdata hold last value when bram_we=0.
REQ-028 abort shall clear pending immediately; no write issued after the abort cycle.

Reset
REQ-029 rst_n low shall force IDLE, cnv_enable=0, busy=0, done=0, overflow=0, bram_we=0, bram_addr=0, bram_wdata=0, counts, pending and arbiter pointer to 0.

Configuration
REQ-030 With ADC_CAPTURE_OVF_COUNT_EN defined, an extra output ovf_count [NUM_CHANNELS][8] shall count dropped samples per channel, saturating at 255, cleared on accepted start and reset; without it the port and counters shall not exist and overflow is unchanged.

Structure
REQ-031 Package adc_capture_pkg shall hold the state enum, sample width 16 and the ovf-count width.
REQ-032 The round-robin arbiter shall be a sub-module rr_arbiter (request vector in, one-hot grant out, pointer update on grant).

Verification
REQ-033 start, num_samples=4, all 4 channels valid same cycle every 10 cycles -> 16 writes, each channel addresses {c,0..3} in order, done after last write, cnv_enable low.
REQ-034 Channel 2 valid on two consecutive cycles while channels 0,1,3 also pending -> overflow[2]=1, second sample absent from BRAM, others unaffected.
REQ-035 num_samples=0 -> each channel writes DEPTH_PER_CH samples, last address {c, DEPTH_PER_CH-1}.
REQ-036 abort after 5 writes -> IDLE next cycle, no further bram_we, busy=0, done=0.
REQ-037 rst_n asserted mid-capture with pending samples -> all outputs at reset values asynchronously, no write on release.
REQ-038 With ADC_CAPTURE_OVF_COUNT_EN, 300 dropped samples on channel 0 -> ovf_count[0]=255.
